game_screen_fsm: RTL and testbench

// Top-level screen sequencer for the game. Owns the WELCOME / PLAY / LEVEL_UP / GAME_OVER

---
 rtl/game_screen_fsm.sv | 174 +++++++++++++++++
 tb/tb_game_screen_fsm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_screen_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : game_screen_fsm
//  Description : Top-level screen sequencer. Steps through WELCOME / PLAY /
//                LEVEL_UP / GAME_OVER, owns the level and lives counters,
//                drives the screen code to the background drawer and gates
//                the gameplay objects.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_screen_fsm #(
    parameter int LIVES        = 3,    // lives loaded on a new game (1..7)
    parameter int NUM_LEVELS   = 4,    // clearing level NUM_LEVELS-1 wins (1..8)
    parameter int PAUSE_FRAMES = 120,  // frames spent in LEVEL_UP
    parameter int OVER_FRAMES  = 180,  // frames before GAME_OVER auto-exits
    parameter int KEY_LOCK     = 30    // frames after GAME_OVER entry ignoring startKey
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       playerHit,
    input  logic       levelCleared,
    output logic [1:0] bgState,
    output logic       gameEnable,
    output logic       newLevelPulse,
    output logic [2:0] level,
    output logic [2:0] lives,
    output logic       gameWon
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The frame counter must be able to reach every limit it is compared to,
    // including the key lock window, so all three limits size it.
    localparam int c_CNT_MAX_PO = (PAUSE_FRAMES > OVER_FRAMES) ? PAUSE_FRAMES : OVER_FRAMES;
    localparam int c_CNT_MAX    = (c_CNT_MAX_PO > KEY_LOCK) ? c_CNT_MAX_PO : KEY_LOCK;
    localparam int c_CNT_W      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PAUSE     = c_CNT_W'(PAUSE_FRAMES);
    localparam logic [c_CNT_W-1:0] c_OVER      = c_CNT_W'(OVER_FRAMES);
    localparam logic [c_CNT_W-1:0] c_LOCK      = c_CNT_W'(KEY_LOCK);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = {c_CNT_W{1'b1}};
    localparam logic [2:0]         c_LIVES     = 3'(LIVES);
    localparam logic [2:0]         c_LAST_LVL  = 3'(NUM_LEVELS - 1);

    // State encoding is exactly the screen code seen by the background drawer.
    typedef enum logic [1:0] {
        S_WELCOME   = 2'b00,
        S_PLAY      = 2'b01,
        S_LEVEL_UP  = 2'b10,
        S_GAME_OVER = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_frame_cnt;
    logic                 r_key_d;
    logic                 r_key_armed;
    logic                 w_key_rise;
    logic                 w_frame_inc;
    logic                 w_over_exit;
    logic                 w_pause_exit;

    // The bgState output is the state register itself: no decode delay.
    assign bgState = r_state;

    // Rising edge of the start key. r_key_armed stays low for the first
    // cycle after reset so a key already held at release never fires.
    assign w_key_rise = startKey & ~r_key_d & r_key_armed;

    // Frame counter advances on each frame pulse until it saturates.
    assign w_frame_inc = startOfFrame & (r_frame_cnt != c_CNT_SAT);

    // Exit conditions look at the count before any same-cycle frame pulse.
    assign w_pause_exit = (r_frame_cnt >= c_PAUSE);
    assign w_over_exit  = (r_frame_cnt >= c_OVER) |
                          (w_key_rise & (r_frame_cnt >= c_LOCK));

    // Key edge detector history.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_key_d     <= 1'b0;
            r_key_armed <= 1'b0;
        end else begin
            r_key_d     <= startKey;
            r_key_armed <= 1'b1;
        end
    end

    // Screen sequencer with registered outputs; every state change also
    // clears the frame counter (the later assignment overrides the count).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_WELCOME;
            r_frame_cnt   <= '0;
            gameEnable    <= 1'b0;
            newLevelPulse <= 1'b0;
            level         <= 3'd0;
            lives         <= c_LIVES;
            gameWon       <= 1'b0;
        end else begin
            newLevelPulse <= 1'b0;
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            case (r_state)
                S_WELCOME: begin
                    if (w_key_rise) begin
                        level         <= 3'd0;
                        lives         <= c_LIVES;
                        gameWon       <= 1'b0;
                        gameEnable    <= 1'b1;
                        newLevelPulse <= 1'b1;
                        r_frame_cnt   <= '0;
                        r_state       <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    // A hit takes priority; a simultaneous clear is dropped.
                    if (playerHit) begin
                        if (lives != 3'd0) begin
                            lives <= lives - 3'd1;
                        end
                        if (lives <= 3'd1) begin
                            gameWon     <= 1'b0;
                            gameEnable  <= 1'b0;
                            r_frame_cnt <= '0;
                            r_state     <= S_GAME_OVER;
                        end
                    end else if (levelCleared) begin
                        gameEnable  <= 1'b0;
                        r_frame_cnt <= '0;
                        if (level >= c_LAST_LVL) begin
                            gameWon <= 1'b1;
                            r_state <= S_GAME_OVER;
                        end else begin
                            level   <= level + 3'd1;
                            r_state <= S_LEVEL_UP;
                        end
                    end
                end

                S_LEVEL_UP: begin
                    if (w_pause_exit) begin
                        gameEnable    <= 1'b1;
                        newLevelPulse <= 1'b1;
                        r_frame_cnt   <= '0;
                        r_state       <= S_PLAY;
                    end
                end

                S_GAME_OVER: begin
                    // level and lives are left untouched for the score display.
                    if (w_over_exit) begin
                        gameWon     <= 1'b0;
                        r_frame_cnt <= '0;
                        r_state     <= S_WELCOME;
                    end
                end

                default: begin
                    r_state <= S_WELCOME;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_screen_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_screen_fsm
//  Description : Self-checking bench for game_screen_fsm: directed scenarios
//                plus a randomized run against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_screen_fsm;

    localparam int LIVES        = 3;
    localparam int NUM_LEVELS   = 4;
    localparam int PAUSE_FRAMES = 120;
    localparam int OVER_FRAMES  = 180;
    localparam int KEY_LOCK     = 30;

    // Screen codes as seen on bgState.
    localparam logic [1:0] SCR_WELCOME = 2'b00;
    localparam logic [1:0] SCR_PLAY    = 2'b01;
    localparam logic [1:0] SCR_LEVELUP = 2'b10;
    localparam logic [1:0] SCR_OVER    = 2'b11;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       startKey;
    logic       playerHit;
    logic       levelCleared;
    logic [1:0] bgState;
    logic       gameEnable;
    logic       newLevelPulse;
    logic [2:0] level;
    logic [2:0] lives;
    logic       gameWon;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_screen_fsm #(
        .LIVES        (LIVES),
        .NUM_LEVELS   (NUM_LEVELS),
        .PAUSE_FRAMES (PAUSE_FRAMES),
        .OVER_FRAMES  (OVER_FRAMES),
        .KEY_LOCK     (KEY_LOCK)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .startKey      (startKey),
        .playerHit     (playerHit),
        .levelCleared  (levelCleared),
        .bgState       (bgState),
        .gameEnable    (gameEnable),
        .newLevelPulse (newLevelPulse),
        .level         (level),
        .lives         (lives),
        .gameWon       (gameWon)
    );

    // ------------------------------------------------------------------------
    // Behavioural game model: what the player should see after each clock.
    // ------------------------------------------------------------------------
    logic [1:0] m_screen;
    logic [2:0] m_level;
    logic [2:0] m_lives;
    logic       m_won;
    logic       m_fresh;      // first cycle of a PLAY screen
    int         m_frames;     // frames seen since the screen was entered
    logic       m_prev_key;
    logic       m_key_ok;     // a key edge can be recognised

    function automatic void model_reset();
        m_screen   = SCR_WELCOME;
        m_level    = 3'd0;
        m_lives    = 3'(LIVES);
        m_won      = 1'b0;
        m_fresh    = 1'b0;
        m_frames   = 0;
        m_prev_key = 1'b0;
        m_key_ok   = 1'b0;
    endfunction

    function automatic void model_step();
        logic       press;
        logic [1:0] next;
        if (!resetN) begin
            model_reset();
            return;
        end
        press = startKey && !m_prev_key && m_key_ok;
        next  = m_screen;
        case (m_screen)
            SCR_WELCOME: if (press) begin
                m_level = 3'd0; m_lives = 3'(LIVES); m_won = 1'b0; next = SCR_PLAY;
            end
            SCR_PLAY: if (playerHit) begin
                m_lives = m_lives - 3'd1;
                if (m_lives == 3'd0) begin next = SCR_OVER; m_won = 1'b0; end
            end else if (levelCleared) begin
                if (int'(m_level) == NUM_LEVELS - 1) begin next = SCR_OVER; m_won = 1'b1; end
                else begin next = SCR_LEVELUP; m_level = m_level + 3'd1; end
            end
            SCR_LEVELUP: if (m_frames >= PAUSE_FRAMES) next = SCR_PLAY;
            default: if (m_frames >= OVER_FRAMES || (press && m_frames >= KEY_LOCK)) begin
                next = SCR_WELCOME; m_won = 1'b0;
            end
        endcase
        m_fresh = (next == SCR_PLAY) && (m_screen != SCR_PLAY);
        if (next != m_screen)                    m_frames = 0;
        else if (startOfFrame && m_frames < 1000) m_frames = m_frames + 1;
        m_screen   = next;
        m_prev_key = startKey;
        m_key_ok   = 1'b1;
    endfunction

    // One clock: inputs already stable, model follows the edge, sample 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frame_pulse();
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0; tick();
    endtask

    task automatic press_key();
        startKey = 1'b1; tick();
        startKey = 1'b0; tick();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b1;
        playerHit = 1'b0; levelCleared = 1'b0;
        model_reset();
        repeat (3) tick();
        n_checks++; if (bgState !== SCR_WELCOME) begin n_fail++; $display("FAIL reset_bg: got %0d expected %0d", bgState, SCR_WELCOME); end
        n_checks++; if (gameEnable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %0b expected 0", gameEnable); end
        n_checks++; if (newLevelPulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b expected 0", newLevelPulse); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (lives !== 3'(LIVES)) begin n_fail++; $display("FAIL reset_lives: got %0d expected %0d", lives, LIVES); end
        n_checks++; if (gameWon !== 1'b0) begin n_fail++; $display("FAIL reset_won: got %0b expected 0", gameWon); end
        // Key held high across reset release must not start a game.
        resetN = 1'b1;
        repeat (3) tick();
        n_checks++; if (bgState !== SCR_WELCOME) begin n_fail++; $display("FAIL held_key_bg: got %0d expected %0d", bgState, SCR_WELCOME); end
        startKey = 1'b0;
        tick();
    endtask

    task automatic test_start();
        startKey = 1'b1; tick();
        n_checks++; if (bgState !== SCR_PLAY) begin n_fail++; $display("FAIL start_bg: got %0d expected %0d", bgState, SCR_PLAY); end
        n_checks++; if (gameEnable !== 1'b1) begin n_fail++; $display("FAIL start_enable: got %0b expected 1", gameEnable); end
        n_checks++; if (newLevelPulse !== 1'b1) begin n_fail++; $display("FAIL start_pulse: got %0b expected 1", newLevelPulse); end
        n_checks++; if (level !== 3'd0 || lives !== 3'd3) begin n_fail++; $display("FAIL start_counts: got level %0d lives %0d expected 0 3", level, lives); end
        startKey = 1'b0; tick();
        n_checks++; if (newLevelPulse !== 1'b0 || bgState !== SCR_PLAY) begin n_fail++; $display("FAIL start_pulse_len: got pulse %0b bg %0d expected 0 1", newLevelPulse, bgState); end
    endtask

    task automatic test_lose();
        for (int h = 1; h <= 3; h++) begin
            playerHit = 1'b1; tick(); playerHit = 1'b0;
            n_checks++; if (lives !== 3'(3 - h)) begin n_fail++; $display("FAIL lose_lives_%0d: got %0d expected %0d", h, lives, 3 - h); end
        end
        n_checks++; if (bgState !== SCR_OVER || gameWon !== 1'b0 || gameEnable !== 1'b0) begin n_fail++; $display("FAIL lose_over: got bg %0d won %0b en %0b expected 3 0 0", bgState, gameWon, gameEnable); end
        repeat (OVER_FRAMES - 1) frame_pulse();
        n_checks++; if (bgState !== SCR_OVER) begin n_fail++; $display("FAIL lose_hold_179: got %0d expected %0d", bgState, SCR_OVER); end
        frame_pulse();
        n_checks++; if (bgState !== SCR_WELCOME) begin n_fail++; $display("FAIL lose_timeout: got %0d expected %0d", bgState, SCR_WELCOME); end
    endtask

    task automatic test_levels_win();
        press_key();
        for (int l = 0; l < NUM_LEVELS - 1; l++) begin
            levelCleared = 1'b1; tick(); levelCleared = 1'b0;
            n_checks++; if (bgState !== SCR_LEVELUP || level !== 3'(l + 1) || gameEnable !== 1'b0) begin n_fail++; $display("FAIL lvlup_%0d: got bg %0d level %0d en %0b expected 2 %0d 0", l, bgState, level, gameEnable, l + 1); end
            repeat (PAUSE_FRAMES - 1) frame_pulse();
            n_checks++; if (bgState !== SCR_LEVELUP) begin n_fail++; $display("FAIL pause_hold_%0d: got %0d expected %0d", l, bgState, SCR_LEVELUP); end
            frame_pulse();
            n_checks++; if (bgState !== SCR_PLAY || newLevelPulse !== 1'b1) begin n_fail++; $display("FAIL pause_exit_%0d: got bg %0d pulse %0b expected 1 1", l, bgState, newLevelPulse); end
        end
        levelCleared = 1'b1; tick(); levelCleared = 1'b0;
        n_checks++; if (bgState !== SCR_OVER || gameWon !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL win: got bg %0d won %0b level %0d expected 3 1 3", bgState, gameWon, level); end
        repeat (KEY_LOCK) frame_pulse();
        press_key();
        n_checks++; if (bgState !== SCR_WELCOME || gameWon !== 1'b0) begin n_fail++; $display("FAIL win_exit: got bg %0d won %0b expected 0 0", bgState, gameWon); end
    endtask

    task automatic test_hit_and_clear();
        press_key();
        for (int k = 2; k >= 1; k--) begin
            playerHit = 1'b1; levelCleared = 1'b1; tick();
            playerHit = 1'b0; levelCleared = 1'b0;
            n_checks++; if (lives !== 3'(k) || bgState !== SCR_PLAY || level !== 3'd0) begin n_fail++; $display("FAIL hit_clear_%0d: got lives %0d bg %0d level %0d expected %0d 1 0", k, lives, bgState, level, k); end
        end
        playerHit = 1'b1; tick(); playerHit = 1'b0;
        n_checks++; if (bgState !== SCR_OVER) begin n_fail++; $display("FAIL hit_clear_over: got %0d expected %0d", bgState, SCR_OVER); end
    endtask

    // Entered with GAME_OVER freshly reached (frame count 0).
    task automatic test_key_lock();
        repeat (10) frame_pulse();
        press_key();
        n_checks++; if (bgState !== SCR_OVER) begin n_fail++; $display("FAIL lock_f10: got %0d expected %0d", bgState, SCR_OVER); end
        repeat (KEY_LOCK - 11) frame_pulse();
        press_key();
        n_checks++; if (bgState !== SCR_OVER) begin n_fail++; $display("FAIL lock_f29: got %0d expected %0d", bgState, SCR_OVER); end
        frame_pulse();
        startKey = 1'b1; tick();
        n_checks++; if (bgState !== SCR_WELCOME) begin n_fail++; $display("FAIL lock_f30: got %0d expected %0d", bgState, SCR_WELCOME); end
        n_checks++; if (level !== 3'd0 || lives !== 3'd0) begin n_fail++; $display("FAIL lock_hold_counts: got level %0d lives %0d expected 0 0", level, lives); end
        startKey = 1'b0; tick();
    endtask

    task automatic test_reset_mid_levelup();
        press_key();
        levelCleared = 1'b1; tick(); levelCleared = 1'b0;
        repeat (60) frame_pulse();
        #2 resetN = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bgState !== SCR_WELCOME || level !== 3'd0 || lives !== 3'(LIVES)) begin n_fail++; $display("FAIL async_rst: got bg %0d level %0d lives %0d expected 0 0 3", bgState, level, lives); end
        n_checks++; if (gameEnable !== 1'b0 || newLevelPulse !== 1'b0 || gameWon !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: got en %0b pulse %0b won %0b expected 0 0 0", gameEnable, newLevelPulse, gameWon); end
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [10:0] got;
        logic [10:0] exp;
        for (int c = 0; c < 6000; c++) begin
            startOfFrame = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) startKey = ~startKey;
            playerHit    = ($urandom_range(0, 23) == 0);
            levelCleared = ($urandom_range(0, 15) == 0);
            tick();
            got = {bgState, gameEnable, newLevelPulse, level, lives, gameWon};
            exp = {m_screen, (m_screen == SCR_PLAY), m_fresh, m_level, m_lives, m_won};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d: got bg %0d en %0b nlp %0b lvl %0d lives %0d won %0b expected bg %0d en %0b nlp %0b lvl %0d lives %0d won %0b",
                         c, got[10:9], got[8], got[7], got[6:4], got[3:1], got[0],
                         exp[10:9], exp[8], exp[7], exp[6:4], exp[3:1], exp[0]);
            end
        end
        startOfFrame = 1'b0; startKey = 1'b0; playerHit = 1'b0; levelCleared = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_lose();
        test_levels_win();
        test_hit_and_clear();
        test_key_lock();
        test_reset_mid_levelup();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
